// File: rtl/plant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plant_pkg                                                            |
// | Shared types and constants for the plant model and its noise LFSR.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package plant_pkg;

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        SEND   = 2'd1,
        WAIT_U = 2'd2,
        CALC   = 2'd3
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/lfsr_galois.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_galois                                                          |
// | 16-bit right-shifting Galois LFSR, one step per advance pulse.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr_galois
    import plant_pkg::*;
#(
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= seed;
        end else if (advance) begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? TAPS : 16'h0000);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/plant_model_axis.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plant_model_axis                                                     |
// | First-order plant y += (u - y) >>> ALPHA_SHIFT with LFSR measurement |
// | noise, AXI-Stream in (u) and out (y_meas).                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module plant_model_axis
    import plant_pkg::*;
#(
    parameter int          W           = 16,
    parameter int          MAX_VAL     = 32767,
    parameter int          MIN_VAL     = -32768,
    parameter int          ALPHA_SHIFT = 3,
    parameter int          NOISE_BITS  = 4,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_axi_tdata,
    input  logic         s_axi_tvalid,
    output logic         s_axi_tready,
    input  logic         noise_en,
    output logic [W-1:0] m_axi_tdata,
    output logic         m_axi_tvalid,
    input  logic         m_axi_tready
);

    localparam logic signed [W+1:0] C_MAX = (W+2)'(MAX_VAL);
    localparam logic signed [W+1:0] C_MIN = (W+2)'(MIN_VAL);

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        if (v > C_MAX) return C_MAX[W-1:0];
        if (v < C_MIN) return C_MIN[W-1:0];
        return v[W-1:0];
    endfunction

    state_t                r_state;
    logic signed [W-1:0]   r_y;
    logic signed [W-1:0]   r_y_meas;
    logic signed [W-1:0]   r_u;
    logic                  r_s_ready;
    logic                  r_m_valid;

    logic                  w_accept;
    logic [15:0]           w_lfsr;
    logic signed [W:0]     w_diff;
    logic signed [W:0]     w_step;
    logic signed [W+1:0]   w_y_sum;
    logic signed [W-1:0]   w_y_next;
    logic signed [W+1:0]   w_noise;
    logic signed [W+1:0]   w_noise_sel;
    logic signed [W+1:0]   w_meas_sum;
    logic                  w_lfsr_unused;

    // Stepping on the accepting edge means CALC already sees the post-advance value.
    assign w_accept = (r_state == WAIT_U) && s_axi_tvalid;

    lfsr_galois #(
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (LFSR_SEED),
        .advance (w_accept),
        .state   (w_lfsr)
    );

    assign w_diff      = (W+1)'(r_u) - (W+1)'(r_y);
    assign w_step      = w_diff >>> ALPHA_SHIFT;
    assign w_y_sum     = (W+2)'(r_y) + (W+2)'(w_step);
    assign w_y_next    = sat(w_y_sum);
    assign w_noise     = (W+2)'($signed(w_lfsr[NOISE_BITS-1:0]));
    assign w_noise_sel = noise_en ? w_noise : (W+2)'(0);
    assign w_meas_sum  = (W+2)'(w_y_next) + w_noise_sel;
    assign w_lfsr_unused = ^w_lfsr[15:NOISE_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= PRIME;
            r_y       <= '0;
            r_y_meas  <= '0;
            r_u       <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                PRIME: begin
                    r_m_valid <= 1'b1;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (m_axi_tready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= WAIT_U;
                    end
                end
                WAIT_U: begin
                    if (s_axi_tvalid) begin
                        r_u       <= s_axi_tdata;
                        r_s_ready <= 1'b0;
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    r_y       <= w_y_next;
                    r_y_meas  <= sat(w_meas_sum);
                    r_m_valid <= 1'b1;
                    r_state   <= SEND;
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_state   <= PRIME;
                end
            endcase
        end
    end

    assign s_axi_tready = r_s_ready;
    assign m_axi_tvalid = r_m_valid;
    assign m_axi_tdata  = r_y_meas;

endmodule
`default_nettype wire

// File: tb/tb_plant_model_axis.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_plant_model_axis                                                  |
// | Scoreboard bench: driver pushes model predictions, monitor pops them.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_plant_model_axis;

    localparam int ALPHA = 3;
    localparam int DIV   = 1 << ALPHA;
    localparam int SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        noise_en = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;

    int ready_mode = 1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_data = 0;
    int exp_q[$];

    int m_y;
    int m_lfsr;

    plant_model_axis dut (
        .clk          (clk),
        .reset        (reset),
        .s_axi_tdata  (s_data),
        .s_axi_tvalid (s_valid),
        .s_axi_tready (s_ready),
        .noise_en     (noise_en),
        .m_axi_tdata  (m_data),
        .m_axi_tvalid (m_valid),
        .m_axi_tready (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_div(input int d);
        if (d >= 0) return d / DIV;
        return -((-d + DIV - 1) / DIV);
    endfunction

    function automatic int lfsr_step(input int s);
        if ((s % 2) == 1) return (s / 2) ^ 16'hB400;
        return s / 2;
    endfunction

    task automatic model_beat(input int u, input bit ne);
        int n;
        m_lfsr = lfsr_step(m_lfsr);
        m_y    = sat(m_y + floor_div(u - m_y));
        n      = m_lfsr % 16;
        if (n >= 8) n = n - 16;
        exp_q.push_back(sat(m_y + (ne ? n : 0)));
    endtask

    // Monitor: scoreboard pops, AXI hold rules, handshake exclusivity, latency.
    bit prev_hold = 0;
    int prev_data = 0;
    bit prev_valid = 0;
    bit hs_pending = 0;
    int hs_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold  = 0;
            prev_valid = 0;
            hs_pending = 0;
        end else begin
            chk("no_overlap", int'(m_valid && s_ready), 0);
            if (prev_hold) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'($signed(m_data)), prev_data);
            end
            if (m_valid && !prev_valid && hs_pending) begin
                chk("latency", cyc - hs_cyc, 2);
                hs_pending = 0;
            end
            if (s_valid && s_ready) begin
                hs_pending = 1;
                hs_cyc     = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", int'(m_valid), 0);
                else chk("meas", int'($signed(m_data)), exp_q.pop_front());
                last_data = int'($signed(m_data));
            end
            prev_hold  = m_valid && !m_ready;
            prev_data  = int'($signed(m_data));
            prev_valid = m_valid;
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_sready", int'(s_ready), 0);
        exp_q.delete();
        m_y    = 0;
        m_lfsr = SEED;
        exp_q.push_back(0);
        reset = 1'b0;
        @(negedge clk);
        chk("prime_valid", int'(m_valid), 0);
        chk("prime_sready", int'(s_ready), 0);
        @(negedge clk);
        chk("first_valid", int'(m_valid), 1);
        chk("first_data", int'($signed(m_data)), 0);
        @(negedge clk);
        chk("sready_after_first", int'(s_ready), 1);
        @(posedge clk);
        #1;
    endtask

    // Presents u until accepted, keeps noise_en steady through CALC.
    task automatic send(input int u, input bit ne, input bit rst_in_calc);
        int n;
        int uv;
        uv       = u;
        s_data   = uv[15:0];
        noise_en = ne;
        s_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("s_accept_timeout", int'(s_ready), 1);
            s_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        model_beat(u, ne);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (rst_in_calc) begin
            reset = 1'b1;
            #1;
            chk("calc_rst_valid", int'(m_valid), 0);
            chk("calc_rst_data", int'(m_data), 0);
            chk("calc_rst_sready", int'(s_ready), 0);
            exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int u;
        int d0;
        int n;
        ready_mode = 1;
        do_reset();

        send(800, 0, 0);
        drain("drain_800a");
        chk("plan_800a", last_data, 100);
        send(800, 0, 0);
        drain("drain_800b");
        chk("plan_800b", last_data, 187);

        do_reset();
        send(-1, 0, 0);
        drain("drain_neg1");
        chk("plan_neg1", last_data, -1);
        send(-8, 0, 0);
        drain("drain_neg8");
        chk("plan_neg8", last_data, -2);

        do_reset();
        send(0, 1, 0);
        drain("drain_noise1");
        chk("plan_noise1", last_data, 0);
        send(0, 1, 0);
        drain("drain_noise2");
        chk("plan_noise2", last_data, -8);
        send(0, 0, 0);
        drain("drain_noise_y");
        chk("plan_y_clean", last_data, 0);

        for (int i = 0; i < 40; i++) send(32767, 1, 0);
        for (int i = 0; i < 60; i++) send(-32768, 1, 0);
        drain("drain_sat");

        ready_mode = 0;
        send(1234, 0, 0);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        d0 = int'($signed(m_data));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(m_valid), 1);
            chk("bp_sready", int'(s_ready), 0);
            chk("bp_data", int'($signed(m_data)), d0);
        end
        ready_mode = 1;
        drain("drain_bp");

        send(2000, 0, 1);
        do_reset();
        send(0, 1, 0);
        drain("drain_reseed1");
        chk("reseed_noise1", last_data, 0);
        send(0, 1, 0);
        drain("drain_reseed2");
        chk("reseed_noise2", last_data, -8);

        do_reset();
        ready_mode = 0;
        send(500, 0, 0);
        chk("send_valid_pre_rst", int'(m_valid), 1);
        reset = 1'b1;
        #1;
        chk("send_rst_valid", int'(m_valid), 0);
        chk("send_rst_data", int'(m_data), 0);
        exp_q.delete();
        ready_mode = 1;
        do_reset();

        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       u = 32767;
                1:       u = -32768;
                default: u = int'($urandom_range(0, 65535)) - 32768;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(u, 1'($urandom_range(0, 1)), 0);
        end
        ready_mode = 1;
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plant_model_axis.md
# plant_model_axis

First-order discrete plant model with additive pseudo-random measurement noise, forming the opposite end of the closed loop from the PID controller. It accepts control samples u on an AXI-Stream slave and returns noisy measurement samples y on an AXI-Stream master. Its output feeds the controller's feedback input, and the controller's output feeds this block's input. After reset it emits an initial measurement first, so the loop starts without deadlock.

## Interface
- W, 16: sample width, signed two's complement.
- MAX_VAL, 32767: saturation upper bound (signed).
- MIN_VAL, -32768: saturation lower bound (signed).
- ALPHA_SHIFT, 3: plant pole; the gain per step is 2^-ALPHA_SHIFT. Legal range is 1..8.
- NOISE_BITS, 4: width of the signed noise term. Legal range is 1..8.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- clk  in  1  the single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- s_axi_tdata  in  W  control sample u (signed).
- s_axi_tvalid  in  1  u valid.
- s_axi_tready  out  1  block accepts u.
- noise_en  in  1  1 = add noise to the measurement; 0 = noise term forced to 0. Sampled in CALC.
- m_axi_tdata  out  W  measurement y_meas (signed), registered.
- m_axi_tvalid  out  1  measurement valid.
- m_axi_tready  in  1  downstream accepts the measurement.

## Operation
- State: plant register y (W bits, signed), measurement register y_meas, 16-bit LFSR, FSM.
- FSM states are PRIME, SEND, WAIT_U and CALC.
  - PRIME is the reset state. It lasts one cycle with both handshakes inactive, then goes to SEND.
  - SEND: m_axi_tvalid=1. On m_axi_tvalid && m_axi_tready, go to WAIT_U.
  - WAIT_U: s_axi_tready=1. On s_axi_tvalid && s_axi_tready, latch u and go to CALC.
  - CALC: update y, y_meas and the LFSR, then go to SEND.
- Plant update in CALC:
  - diff = u - y, computed in W+1 bits.
  - step = diff >>> ALPHA_SHIFT, an arithmetic shift that floors toward -inf.
  - y_next = sat(y + step), summed in W+2 bits and clamped to [MIN_VAL, MAX_VAL].
- Noise:
  - noise = sign-extended LFSR[NOISE_BITS-1:0], using the LFSR value after this CALC's advance.
  - y_meas = sat(y_next + (noise_en ? noise : 0)).
  - Noise never feeds back into y.
- LFSR:
  - Galois, right-shifting, taps 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Advances exactly once per CALC and never otherwise.
  - The output bit (bit 0) is shifted out; the register is XORed with the taps when that bit is 1.
- The two handshakes never overlap: s_axi_tready=1 only in WAIT_U, m_axi_tvalid=1 only in SEND.

## Timing
- Reset values: y=0, y_meas=0, LFSR=LFSR_SEED, state=PRIME.
  - Outputs during reset: m_axi_tvalid=0, m_axi_tdata=0, s_axi_tready=0.
- First measurement: m_axi_tvalid rises in the 2nd cycle after reset deasserts (PRIME, then SEND) with m_axi_tdata=0.
- Latency: s_axi handshake in cycle t gives CALC in t+1 and m_axi_tvalid=1 in t+2.
- Minimum period is 3 cycles per sample with zero backpressure.
- In SEND, m_axi_tdata and m_axi_tvalid are held stable until the handshake (AXI rule: tvalid never drops without tready).
- In WAIT_U, s_axi_tready stays high until a beat is accepted; an idle s_axi_tvalid=0 stalls indefinitely.
- Reset mid-operation (any state, including CALC or SEND with tvalid high) returns immediately to the reset values. The pending beat is discarded and the LFSR is reseeded.
- Saturation applies at both the y and y_meas stages. Overflow never wraps.

## Structure
- Package plant_pkg holds:
  - the state enum {PRIME, SEND, WAIT_U, CALC};
  - LFSR_TAPS = 16'hB400;
  - the default LFSR_SEED.
- Sub-module lfsr_galois (16-bit, inputs seed and advance, output state).
  - It is reused by other noise sources in the system.
- Saturation is a local function or a combinational block inside plant_model_axis.

## Test plan
- Reset release with m_axi_tready=1 and noise_en=0 -> first beat is y_meas=0, 2 cycles after deassert; s_axi_tready goes high next.
- ALPHA_SHIFT=3, noise_en=0, send u=800 twice -> measurements 100, then 187 (100 + (700>>>3)). Latency from s handshake to m_axi_tvalid is exactly 2 cycles.
- Negative floor: from y=0, u=-1 -> y=-1. Then u=-8 -> y=-1 + (-7>>>3) = -2.
- Noise: noise_en=1, seed 16'hACE1, u=0 from y=0 -> first post-input noise is 0 (LFSR=16'hE270), giving y_meas=0. Second is -8 (LFSR=16'h7138), giving y_meas=-8, while internal y stays 0.
- Saturation and backpressure:
  - Drive y to 32767 with noise +7 -> y_meas=32767.
  - Hold m_axi_tready=0 for 5 cycles -> m_axi_tdata is stable and s_axi_tready=0 throughout.
- Assert reset during CALC -> all outputs 0 immediately. After release the sequence restarts with y_meas=0 and the LFSR sequence repeats from the seed.
